// File: rtl/csr_unit_if.sv
// System-op bus between the execute stage and the CSR unit.
// The master drives the instruction slot; the slave returns CSR data and redirects.
interface csr_unit_if #(
    parameter int XLEN = 64
);
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      op;
    logic [11:0]     addr;
    logic [XLEN-1:0] tval;
    logic [XLEN-1:0] wdata;
    logic            instret;
    logic            irq_m_ext;
    logic            irq_m_timer;
    logic            irq_m_soft;
    logic            irq_s_ext;
    logic [XLEN-1:0] rdata;
    logic            r_valid;
    logic [1:0]      priv;
    logic [XLEN-1:0] satp;
    logic            trap_en;
    logic [XLEN-1:0] trap_pc;
    logic            flush;

    modport master (
        output valid, pc, op, addr, tval, wdata, instret,
               irq_m_ext, irq_m_timer, irq_m_soft, irq_s_ext,
        input  rdata, r_valid, priv, satp, trap_en, trap_pc, flush
    );

    modport slave (
        input  valid, pc, op, addr, tval, wdata, instret,
               irq_m_ext, irq_m_timer, irq_m_soft, irq_s_ext,
        output rdata, r_valid, priv, satp, trap_en, trap_pc, flush
    );
endinterface

// File: rtl/csr_unit.sv
// Machine/supervisor CSR file: CSR access, trap entry/return, interrupt
// arbitration with M->S delegation, cycle/instret counters, satp and privilege.
module csr_unit #(
    parameter int          XLEN       = 64,
    parameter logic [63:0] RESET_VEC  = 64'h0,
    parameter int          HART_ID    = 0,
    parameter bit          HAS_S_MODE = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    csr_unit_if.slave bus
);
    localparam logic [4:0] SYSOP_RET   = 5'h01;
    localparam logic [4:0] SYSOP_CSR_W = 5'h02;
    localparam logic [4:0] SYSOP_CSR_S = 5'h03;
    localparam logic [4:0] SYSOP_CSR_C = 5'h04;

    localparam logic [XLEN-1:0] MXL = (XLEN == 64) ? (XLEN'(2) << (XLEN-2)) : (XLEN'(1) << (XLEN-2));
    // RV-I with U mode, plus S when present
    localparam logic [XLEN-1:0] MISA_INIT_VAL = MXL | XLEN'(32'h0010_0100) |
                                                (HAS_S_MODE ? XLEN'(32'h0004_0000) : '0);
    // mstatus fields kept: SIE(1) MIE(3) SPIE(5) MPIE(7) SPP(8) MPP(12:11)
    localparam logic [XLEN-1:0] MSTATUS_WMASK = HAS_S_MODE ? XLEN'(32'h19AA) : XLEN'(32'h1888);
    localparam logic [XLEN-1:0] SSTATUS_MASK  = XLEN'(32'h0122);
    localparam logic [XLEN-1:0] MIE_WMASK     = HAS_S_MODE ? XLEN'(32'h0AAA) : XLEN'(32'h0888);
    localparam logic [XLEN-1:0] S_IRQ_MASK    = XLEN'(32'h0222);
    localparam logic [XLEN-1:0] MIP_WMASK     = HAS_S_MODE ? XLEN'(32'h0022) : '0;
    localparam logic [XLEN-1:0] SIP_WMASK     = XLEN'(32'h0002);
    localparam logic [XLEN-1:0] MEDELEG_MASK  = HAS_S_MODE ? XLEN'(32'hFFFF) : '0;
    localparam logic [XLEN-1:0] MIDELEG_MASK  = HAS_S_MODE ? S_IRQ_MASK : '0;
    // Interrupt causes listed from lowest to highest priority (MEI highest)
    localparam int IRQ_PRIO [6] = '{5, 1, 9, 7, 3, 11};

    typedef enum logic [1:0] {ACT_NONE, ACT_TRAP, ACT_RET, ACT_CSR} act_t;

    logic [1:0]      r_priv;
    logic [XLEN-1:0] r_mstatus, r_medeleg, r_mideleg, r_mie, r_mip_sw, r_mtvec, r_mscratch;
    logic [XLEN-1:0] r_mepc, r_mcause, r_mtval, r_stvec, r_sscratch, r_sepc, r_scause, r_stval;
    logic [XLEN-1:0] r_satp, r_mcycle, r_minstret;

    logic [XLEN-1:0] w_mip, w_rd, w_wval, w_mstatus_wr, w_pend, w_irq_cand;
    logic [XLEN-1:0] w_tvec, w_trap_tval, w_trap_cause, w_trap_pc;
    logic            w_impl, w_csr_op, w_csr_ill, w_ret_ill, w_irq_take, w_deleg;
    logic            w_m_en, w_s_en, w_trap_intr, w_satp_wr;
    logic [3:0]      w_irq_code, w_trap_code;
    act_t            w_act;

    // Pending view: hardware lines merged with the software-writable SSIP/STIP
    always_comb begin
        w_mip     = r_mip_sw;
        w_mip[11] = bus.irq_m_ext;
        w_mip[9]  = HAS_S_MODE && bus.irq_s_ext;
        w_mip[7]  = bus.irq_m_timer;
        w_mip[3]  = bus.irq_m_soft;
    end

    // CSR read mux and implemented-address decode
    always_comb begin
        w_rd   = '0;
        w_impl = 1'b1;
        case (bus.addr)
            12'h300: w_rd = r_mstatus;
            12'h301: w_rd = MISA_INIT_VAL;
            12'h302: w_rd = r_medeleg;
            12'h303: w_rd = r_mideleg;
            12'h304: w_rd = r_mie;
            12'h305: w_rd = r_mtvec;
            12'h340: w_rd = r_mscratch;
            12'h341: w_rd = r_mepc;
            12'h342: w_rd = r_mcause;
            12'h343: w_rd = r_mtval;
            12'h344: w_rd = w_mip;
            12'hF14: w_rd = XLEN'(HART_ID);
            12'hB00, 12'hC00: w_rd = r_mcycle;
            12'hB02, 12'hC02: w_rd = r_minstret;
            12'h100: if (HAS_S_MODE) w_rd = r_mstatus & SSTATUS_MASK; else w_impl = 1'b0;
            12'h104: if (HAS_S_MODE) w_rd = r_mie & S_IRQ_MASK;       else w_impl = 1'b0;
            12'h144: if (HAS_S_MODE) w_rd = w_mip & S_IRQ_MASK;       else w_impl = 1'b0;
            12'h105: if (HAS_S_MODE) w_rd = r_stvec;                  else w_impl = 1'b0;
            12'h140: if (HAS_S_MODE) w_rd = r_sscratch;               else w_impl = 1'b0;
            12'h141: if (HAS_S_MODE) w_rd = r_sepc;                   else w_impl = 1'b0;
            12'h142: if (HAS_S_MODE) w_rd = r_scause;                 else w_impl = 1'b0;
            12'h143: if (HAS_S_MODE) w_rd = r_stval;                  else w_impl = 1'b0;
            12'h180: if (HAS_S_MODE) w_rd = r_satp;                   else w_impl = 1'b0;
            default: w_impl = 1'b0;
        endcase
    end

    // Write operand, mstatus legalisation (MPP never takes a reserved level) and legality
    always_comb begin
        case (bus.op)
            SYSOP_CSR_S: w_wval = w_rd | bus.wdata;
            SYSOP_CSR_C: w_wval = w_rd & ~bus.wdata;
            default:     w_wval = bus.wdata;
        endcase
        w_mstatus_wr = (r_mstatus & ~MSTATUS_WMASK) | (w_wval & MSTATUS_WMASK);
        if (w_wval[12:11] == 2'b10 || (!HAS_S_MODE && w_wval[12:11] == 2'b01))
            w_mstatus_wr[12:11] = r_mstatus[12:11];
        w_csr_op  = (bus.op == SYSOP_CSR_W) || (bus.op == SYSOP_CSR_S) || (bus.op == SYSOP_CSR_C);
        w_csr_ill = w_csr_op && (!w_impl || (bus.addr[9:8] > r_priv) || (bus.addr[11:10] == 2'b11));
        w_ret_ill = (bus.op == SYSOP_RET) && (r_priv == 2'b00);
    end

    // Interrupt arbitration: enabled M-level and delegated S-level sources, fixed priority
    always_comb begin
        w_pend     = w_mip & r_mie;
        w_m_en     = (r_priv != 2'b11) || r_mstatus[3];
        w_s_en     = (r_priv == 2'b00) || ((r_priv == 2'b01) && r_mstatus[1]);
        w_irq_cand = (w_m_en ? (w_pend & ~r_mideleg) : '0) | (w_s_en ? (w_pend & r_mideleg) : '0);
        w_irq_code = 4'd0;
        for (int i = 0; i < 6; i++)
            if (w_irq_cand[IRQ_PRIO[i]]) w_irq_code = 4'(IRQ_PRIO[i]);
        w_irq_take = |w_irq_cand[11:0];
    end

    // Action select: interrupt > exception > illegal > RET > CSR op
    always_comb begin
        w_act       = ACT_NONE;
        w_trap_intr = 1'b0;
        w_trap_code = 4'd0;
        w_trap_tval = '0;
        if (bus.valid) begin
            if (w_irq_take) begin
                w_act       = ACT_TRAP;
                w_trap_intr = 1'b1;
                w_trap_code = w_irq_code;
            end else if (bus.op[4]) begin
                w_act       = ACT_TRAP;
                w_trap_code = bus.op[3:0];
                w_trap_tval = bus.tval;
            end else if (w_csr_ill || w_ret_ill) begin
                w_act       = ACT_TRAP;
                w_trap_code = 4'd2;
            end else if (bus.op == SYSOP_RET) begin
                w_act = ACT_RET;
            end else if (w_csr_op) begin
                w_act = ACT_CSR;
            end
        end
        w_deleg      = HAS_S_MODE && (r_priv <= 2'b01) &&
                       (w_trap_intr ? r_mideleg[w_trap_code] : r_medeleg[w_trap_code]);
        w_trap_cause = {w_trap_intr, {(XLEN-5){1'b0}}, w_trap_code};
        w_tvec       = w_deleg ? r_stvec : r_mtvec;
        w_satp_wr    = (w_act == ACT_CSR) && (bus.addr == 12'h180);
    end

    // Redirect target for traps, returns and the satp flush
    always_comb begin
        w_trap_pc = bus.pc + XLEN'(4);
        case (w_act)
            ACT_TRAP: w_trap_pc = {w_tvec[XLEN-1:2], 2'b00} +
                                  ((w_tvec[1:0] == 2'b01 && w_trap_intr) ?
                                   {{(XLEN-6){1'b0}}, w_trap_code, 2'b00} : '0);
            ACT_RET:  w_trap_pc = (r_priv == 2'b11) ? r_mepc : r_sepc;
            default:  w_trap_pc = bus.pc + XLEN'(4);
        endcase
    end

    assign bus.rdata   = w_rd;
    assign bus.r_valid = (w_act == ACT_CSR);
    assign bus.priv    = r_priv;
    assign bus.satp    = r_satp;
    assign bus.trap_en = (w_act == ACT_TRAP) || (w_act == ACT_RET) || w_satp_wr;
    assign bus.trap_pc = w_trap_pc;
    assign bus.flush   = w_satp_wr;

    // State update: counters always run; at most one trap/return/CSR write commits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_priv     <= 2'b11;
            r_mstatus  <= '0;  r_medeleg  <= '0;  r_mideleg <= '0;  r_mie    <= '0;
            r_mip_sw   <= '0;  r_mtvec    <= RESET_VEC[XLEN-1:0];   r_mscratch <= '0;
            r_mepc     <= '0;  r_mcause   <= '0;  r_mtval   <= '0;  r_stvec  <= '0;
            r_sscratch <= '0;  r_sepc     <= '0;  r_scause  <= '0;  r_stval  <= '0;
            r_satp     <= '0;  r_mcycle   <= '0;  r_minstret <= '0;
        end else begin
            r_mcycle <= r_mcycle + XLEN'(1);
            if (bus.instret) r_minstret <= r_minstret + XLEN'(1);
            case (w_act)
                ACT_TRAP: begin
                    if (w_deleg) begin
                        r_sepc       <= bus.pc;
                        r_scause     <= w_trap_cause;
                        r_stval      <= w_trap_tval;
                        r_mstatus[5] <= r_mstatus[1];
                        r_mstatus[1] <= 1'b0;
                        r_mstatus[8] <= (r_priv != 2'b00);
                        r_priv       <= 2'b01;
                    end else begin
                        r_mepc           <= bus.pc;
                        r_mcause         <= w_trap_cause;
                        r_mtval          <= w_trap_tval;
                        r_mstatus[7]     <= r_mstatus[3];
                        r_mstatus[3]     <= 1'b0;
                        r_mstatus[12:11] <= r_priv;
                        r_priv           <= 2'b11;
                    end
                end
                ACT_RET: begin
                    if (r_priv == 2'b11) begin
                        r_mstatus[3]     <= r_mstatus[7];
                        r_mstatus[7]     <= 1'b1;
                        r_priv           <= r_mstatus[12:11];
                        r_mstatus[12:11] <= 2'b00;
                    end else begin
                        r_mstatus[1] <= r_mstatus[5];
                        r_mstatus[5] <= 1'b1;
                        r_priv       <= {1'b0, r_mstatus[8]};
                        r_mstatus[8] <= 1'b0;
                    end
                end
                ACT_CSR: begin
                    case (bus.addr)
                        12'h300: r_mstatus  <= w_mstatus_wr;
                        12'h302: r_medeleg  <= w_wval & MEDELEG_MASK;
                        12'h303: r_mideleg  <= w_wval & MIDELEG_MASK;
                        12'h304: r_mie      <= w_wval & MIE_WMASK;
                        12'h305: r_mtvec    <= w_wval;
                        12'h340: r_mscratch <= w_wval;
                        12'h341: r_mepc     <= w_wval;
                        12'h342: r_mcause   <= w_wval;
                        12'h343: r_mtval    <= w_wval;
                        12'h344: r_mip_sw   <= w_wval & MIP_WMASK;
                        12'hB00: r_mcycle   <= w_wval;
                        12'hB02: r_minstret <= w_wval;
                        12'h100: r_mstatus  <= (r_mstatus & ~SSTATUS_MASK) | (w_wval & SSTATUS_MASK);
                        12'h104: r_mie      <= (r_mie & ~S_IRQ_MASK) | (w_wval & S_IRQ_MASK);
                        12'h144: r_mip_sw   <= (r_mip_sw & ~SIP_WMASK) | (w_wval & SIP_WMASK);
                        12'h105: r_stvec    <= w_wval;
                        12'h140: r_sscratch <= w_wval;
                        12'h141: r_sepc     <= w_wval;
                        12'h142: r_scause   <= w_wval;
                        12'h143: r_stval    <= w_wval;
                        12'h180: r_satp     <= w_wval;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule
